// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: merges the core's instruction and data sram-like ports onto a
// single AXI3 master. One transaction in flight; the data port wins arbitration.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no transaction; arbitrate inst/data requests
//   RD_ADDR | arvalid held until arready
//   RD_DATA | rready held until a beat with the latched id arrives
//   WR_REQ  | awvalid/wvalid each held until their own handshake
//   WR_RESP | bready held until bvalid
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;

  state_e      state_q;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        src_data_q;
  logic        arvalid_q, awvalid_q, wvalid_q;
  logic        rd_hit;

  // Response status, burst end and write id carry no information for single-beat traffic.
  logic unused_inputs;
  assign unused_inputs = ^{rresp, rlast, bid, bresp};

  // Arbitration and completion strobes; addr_ok is held off while reset is asserted.
  assign data_addr_ok = resetn && (state_q == IDLE) && data_req;
  assign inst_addr_ok = resetn && (state_q == IDLE) && inst_req && !data_req;
  assign rd_hit       = (state_q == RD_DATA) && rvalid && (rid == id_q);
  assign inst_data_ok = rd_hit && !src_data_q;
  assign data_data_ok = (rd_hit && src_data_q) || ((state_q == WR_RESP) && bvalid);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arsize  = size_q;
  assign arvalid = arvalid_q;
  assign rready  = (state_q == RD_DATA);
  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awsize  = size_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = wvalid_q;
  assign wlast   = wvalid_q;
  assign bready  = (state_q == WR_RESP);

  // Transaction FSM: latch the winning request, then walk the AXI channels.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      id_q       <= 4'd0;
      addr_q     <= 32'd0;
      size_q     <= 3'd0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      src_data_q <= 1'b0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req) begin
            src_data_q <= 1'b1;
            id_q       <= DATA_ID;
            addr_q     <= data_addr;
            size_q     <= {1'b0, data_size};
            wstrb_q    <= data_wstrb;
            wdata_q    <= data_wdata;
            if (data_wr) begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end else if (inst_req) begin
            src_data_q <= 1'b0;
            id_q       <= INST_ID;
            addr_q     <= inst_addr;
            size_q     <= 3'd2;
            wstrb_q    <= 4'd0;
            wdata_q    <= 32'd0;
            state_q    <= RD_ADDR;
            arvalid_q  <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid && (rid == id_q)) state_q <= IDLE;
        end
        WR_REQ: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (bvalid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
